// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA overlay stages.
// No logic here, so there is no latency and no backpressure.
package vga_pkg;

    localparam int unsigned DEF_WIDTH  = 640;
    localparam int unsigned DEF_HEIGHT = 480;

    typedef logic [3:0] colour_t;

    typedef struct packed {
        colour_t r;
        colour_t g;
        colour_t b;
    } rgb444_t;

    typedef enum logic {
        DIR_DEC = 1'b0,
        DIR_INC = 1'b1
    } dir_t;

    // Entry 0 is the least significant slot, so the list reads F80 down to F00.
    localparam rgb444_t [7:0] PALETTE = {
        12'hF80, 12'hFFF, 12'hF0F, 12'h0FF,
        12'hFF0, 12'h00F, 12'h0F0, 12'hF00
    };

endpackage

// File: rtl/vga_box_axis.sv
// One axis of the bouncing box: position, INC/DEC direction and a wall-hit strobe.
// Position updates on the clock after iTick; oHit is combinational during iTick; no backpressure.
module vga_box_axis
    import vga_pkg::*;
#(
    parameter int unsigned LIMIT = 576,
    parameter int unsigned STEP  = 4,
    parameter int unsigned START = 288
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iTick,
    output logic [9:0] oPos,
    output logic       oHit
);

    localparam logic [10:0] LIMIT11 = 11'(LIMIT);
    localparam logic [10:0] STEP11  = 11'(STEP);

    logic [9:0]  pos_q;
    dir_t        dir_q;
    logic [10:0] pos11;
    logic [10:0] sum11;
    logic        at_hi;
    logic        at_lo;

    // Eleven bits so pos+STEP cannot wrap before the limit compare.
    assign pos11 = {1'b0, pos_q};
    assign sum11 = pos11 + STEP11;
    assign at_hi = (sum11 >= LIMIT11);
    assign at_lo = (pos11 <= STEP11);

    assign oHit = iTick && ((dir_q == DIR_INC) ? at_hi : at_lo);
    assign oPos = pos_q;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            pos_q <= 10'(START);
            dir_q <= DIR_INC;
        end else if (iTick) begin
            case (dir_q)
                DIR_INC: begin
                    if (at_hi) begin
                        pos_q <= LIMIT11[9:0];
                        dir_q <= DIR_DEC;
                    end else begin
                        pos_q <= sum11[9:0];
                    end
                end
                default: begin
                    if (at_lo) begin
                        pos_q <= 10'd0;
                        dir_q <= DIR_INC;
                    end else begin
                        pos_q <= pos_q - STEP11[9:0];
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/vga_box_overlay.sv
// Draws a bordered, bouncing, colour-cycling square over the pattern generator output.
// Fixed 1-cycle latency on syncs and RGB; streaming pixel path, no backpressure.
module vga_box_overlay
    import vga_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned HEIGHT    = DEF_HEIGHT,
    parameter int unsigned BOX_SIZE  = 64,
    parameter int unsigned BORDER    = 4,
    parameter int unsigned STEP_X    = 4,
    parameter int unsigned STEP_Y    = 2,
    parameter logic        SYNC_IDLE = 1'b1
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [9:0] iCountH,
    input  logic [9:0] iCountV,
    input  logic       iHS,
    input  logic       iVS,
    input  logic [3:0] iRed,
    input  logic [3:0] iGreen,
    input  logic [3:0] iBlue,
    input  logic       iPause,
    output logic       oHS,
    output logic       oVS,
    output logic [3:0] oRed,
    output logic [3:0] oGreen,
    output logic [3:0] oBlue
);

    localparam logic [10:0] W11       = 11'(WIDTH);
    localparam logic [10:0] H11       = 11'(HEIGHT);
    localparam logic [10:0] BOX11     = 11'(BOX_SIZE);
    localparam logic [10:0] BRD11     = 11'(BORDER);
    localparam logic [10:0] INNER11   = 11'(BOX_SIZE - BORDER);

    logic        tick;
    logic        hit_x;
    logic        hit_y;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [2:0]  col_q;
    logic        hs_q;
    logic        vs_q;
    rgb444_t     rgb_q;
    rgb444_t     rgb_d;
    rgb444_t     fill;
    rgb444_t     outline;
    logic [10:0] h11;
    logic [10:0] v11;
    logic [10:0] dh;
    logic [10:0] dv;
    logic        in_active;
    logic        in_box;
    logic        on_border;

    // The tick pixel sits in vertical blanking, so moving here never tears.
    assign tick = !iPause && (iCountH == 10'd0) && (iCountV == 10'(HEIGHT));

    vga_box_axis #(
        .LIMIT (WIDTH - BOX_SIZE),
        .STEP  (STEP_X),
        .START ((WIDTH - BOX_SIZE) / 2)
    ) u_axis_x (
        .iClk  (iClk),
        .iRst  (iRst),
        .iTick (tick),
        .oPos  (pos_x),
        .oHit  (hit_x)
    );

    vga_box_axis #(
        .LIMIT (HEIGHT - BOX_SIZE),
        .STEP  (STEP_Y),
        .START ((HEIGHT - BOX_SIZE) / 2)
    ) u_axis_y (
        .iClk  (iClk),
        .iRst  (iRst),
        .iTick (tick),
        .oPos  (pos_y),
        .oHit  (hit_y)
    );

    assign h11       = {1'b0, iCountH};
    assign v11       = {1'b0, iCountV};
    assign dh        = h11 - {1'b0, pos_x};
    assign dv        = v11 - {1'b0, pos_y};
    assign in_active = (h11 < W11) && (v11 < H11);
    assign in_box    = (h11 >= {1'b0, pos_x}) && (dh < BOX11) &&
                       (v11 >= {1'b0, pos_y}) && (dv < BOX11);
    assign on_border = (dh < BRD11) || (dh >= INNER11) ||
                       (dv < BRD11) || (dv >= INNER11);
    assign fill      = PALETTE[col_q];
    assign outline   = rgb444_t'(~fill);

    always_comb begin
        rgb_d = {iRed, iGreen, iBlue};
        if (!in_active) begin
            rgb_d = '0;
        end else if (in_box) begin
            rgb_d = on_border ? outline : fill;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            hs_q  <= SYNC_IDLE;
            vs_q  <= SYNC_IDLE;
            rgb_q <= '0;
            col_q <= 3'd0;
        end else begin
            hs_q  <= iHS;
            vs_q  <= iVS;
            rgb_q <= rgb_d;
            // A corner hit raises both strobes but still advances the palette by one.
            if (hit_x || hit_y) begin
                col_q <= col_q + 3'd1;
            end
        end
    end

    assign oHS    = hs_q;
    assign oVS    = vs_q;
    assign oRed   = rgb_q.r;
    assign oGreen = rgb_q.g;
    assign oBlue  = rgb_q.b;

endmodule

// File: tb/tb_vga_box_overlay.sv
// Directed bench: default 640x480 overlay plus a 640x640 step-2 overlay for the corner hit.
// Stimulus pushes expected {hs,vs,rgb} per cycle; a negedge monitor pops and compares.
module tb_vga_box_overlay;

    localparam logic [11:0] PAT = 12'h5A3;

    logic       iClk;
    logic       rst_n;
    logic [9:0] cnt_h;
    logic [9:0] cnt_v;
    logic       hs_in;
    logic       vs_in;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       pause;

    logic       a_hs, a_vs, b_hs, b_vs;
    logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b;

    int unsigned cyc;
    int          n_chk;
    int          n_fail;

    typedef struct {
        int unsigned cyc;
        bit          chk_a;
        logic [13:0] exp_a;
        bit          chk_b;
        logic [13:0] exp_b;
        string       name;
    } exp_t;

    exp_t sb[$];

    vga_box_overlay #(
        .WIDTH(640), .HEIGHT(480), .BOX_SIZE(64), .BORDER(4),
        .STEP_X(4), .STEP_Y(2), .SYNC_IDLE(1'b1)
    ) dut_a (
        .iClk(iClk), .iRst(rst_n), .iCountH(cnt_h), .iCountV(cnt_v),
        .iHS(hs_in), .iVS(vs_in), .iRed(red), .iGreen(green), .iBlue(blue),
        .iPause(pause), .oHS(a_hs), .oVS(a_vs), .oRed(a_r), .oGreen(a_g), .oBlue(a_b)
    );

    vga_box_overlay #(
        .WIDTH(640), .HEIGHT(640), .BOX_SIZE(64), .BORDER(4),
        .STEP_X(2), .STEP_Y(2), .SYNC_IDLE(1'b1)
    ) dut_b (
        .iClk(iClk), .iRst(rst_n), .iCountH(cnt_h), .iCountV(cnt_v),
        .iHS(hs_in), .iVS(vs_in), .iRed(red), .iGreen(green), .iBlue(blue),
        .iPause(pause), .oHS(b_hs), .oVS(b_vs), .oRed(b_r), .oGreen(b_g), .oBlue(b_b)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(negedge iClk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc != cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s: sampled at cycle %0d, expected cycle %0d", e.name, cyc, e.cyc);
            end
            if (e.chk_a) check({e.name, "/a"}, {a_hs, a_vs, a_r, a_g, a_b}, e.exp_a);
            if (e.chk_b) check({e.name, "/b"}, {b_hs, b_vs, b_r, b_g, b_b}, e.exp_b);
        end
    end

    // Called just after a posedge; inputs are captured on the next one.
    task automatic apply(input logic [9:0] h, input logic [9:0] v, input logic [1:0] sy,
                         input logic [11:0] pat, input bit ca, input logic [11:0] ea,
                         input bit cb, input logic [11:0] eb, input string nm);
        exp_t e;
        cnt_h = h;
        cnt_v = v;
        {hs_in, vs_in} = sy;
        {red, green, blue} = pat;
        e.cyc   = cyc + 1;
        e.chk_a = ca;
        e.exp_a = {sy, ea};
        e.chk_b = cb;
        e.exp_b = {sy, eb};
        e.name  = nm;
        sb.push_back(e);
        @(posedge iClk);
        #1;
    endtask

    task automatic probe_a(input logic [9:0] h, input logic [9:0] v,
                           input logic [11:0] ea, input string nm);
        apply(h, v, 2'b10, PAT, 1'b1, ea, 1'b0, 12'h000, nm);
    endtask

    task automatic probe_b(input logic [9:0] h, input logic [9:0] v,
                           input logic [11:0] ea, input logic [11:0] eb, input string nm);
        apply(h, v, 2'b01, PAT, 1'b1, ea, 1'b1, eb, nm);
    endtask

    // Frame tick for the 480-line instance; the 640-line one sees a pattern pixel at x=0.
    task automatic tick_a(input int n);
        for (int i = 0; i < n; i++) apply(10'd0, 10'd480, 2'b00, PAT, 1'b1, 12'h000, 1'b1, PAT, "tick_a");
    endtask

    task automatic tick_b(input int n);
        for (int i = 0; i < n; i++) apply(10'd0, 10'd640, 2'b00, PAT, 1'b1, 12'h000, 1'b1, 12'h000, "tick_b");
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        pause  = 1'b0;
        cnt_h  = 10'd288;
        cnt_v  = 10'd208;
        hs_in  = 1'b0;
        vs_in  = 1'b0;
        {red, green, blue} = 12'hFFF;

        repeat (3) @(posedge iClk);
        #2;
        check("reset_a", {a_hs, a_vs, a_r, a_g, a_b}, 14'h3000);
        check("reset_b", {b_hs, b_vs, b_r, b_g, b_b}, 14'h3000);
        rst_n = 1'b1;
        #1;
        check("release_a", {a_hs, a_vs, a_r, a_g, a_b}, 14'h3000);
        check("release_b", {b_hs, b_vs, b_r, b_g, b_b}, 14'h3000);

        probe_a(10'd288, 10'd208, 12'h0FF, "start_corner");
        probe_b(10'd288, 10'd288, PAT, 12'h0FF, "b_start_corner");
        probe_b(10'd320, 10'd320, PAT, 12'hF00, "b_start_fill");

        probe_a(10'd100, 10'd100, PAT, "pattern");
        apply(10'd10, 10'd10, 2'b11, 12'h9C1, 1'b1, 12'h9C1, 1'b0, 12'h000, "pattern2");
        probe_a(10'd700, 10'd100, 12'h000, "h_blank");
        probe_a(10'd1, 10'd480, 12'h000, "v_blank");
        probe_a(10'd639, 10'd479, PAT, "last_active");
        probe_a(10'd320, 10'd240, 12'hF00, "centre_fill");
        probe_a(10'd291, 10'd240, 12'h0FF, "left_border");
        probe_a(10'd292, 10'd240, 12'hF00, "left_inner");
        probe_a(10'd347, 10'd240, 12'hF00, "right_inner");
        probe_a(10'd348, 10'd240, 12'h0FF, "right_border");
        probe_a(10'd352, 10'd240, PAT, "right_outside");
        probe_a(10'd320, 10'd211, 12'h0FF, "top_border");
        probe_a(10'd320, 10'd212, 12'hF00, "top_inner");
        probe_a(10'd287, 10'd208, PAT, "left_outside");

        tick_a(1);
        probe_a(10'd292, 10'd210, 12'h0FF, "tick1_corner");
        probe_a(10'd291, 10'd210, PAT, "tick1_left");
        probe_a(10'd292, 10'd209, PAT, "tick1_above");
        probe_a(10'd355, 10'd273, 12'h0FF, "tick1_br");
        probe_a(10'd356, 10'd273, PAT, "tick1_right");

        pause = 1'b1;
        tick_a(1);
        probe_a(10'd292, 10'd210, 12'h0FF, "pause_corner");
        probe_a(10'd291, 10'd210, PAT, "pause_left");
        pause = 1'b0;

        tick_a(70);
        probe_a(10'd572, 10'd350, 12'h0FF, "tick71_corner");
        tick_a(1);
        probe_a(10'd576, 10'd352, 12'hF0F, "tick72_corner");
        probe_a(10'd575, 10'd352, PAT, "tick72_left");
        probe_a(10'd608, 10'd384, 12'h0F0, "tick72_fill");
        probe_a(10'd639, 10'd415, 12'hF0F, "tick72_br");
        tick_a(1);
        probe_a(10'd572, 10'd354, 12'hF0F, "tick73_corner");
        probe_a(10'd604, 10'd386, 12'h0F0, "tick73_fill");
        probe_a(10'd636, 10'd354, PAT, "tick73_right");

        tick_a(31);
        probe_a(10'd448, 10'd416, 12'hFF0, "tick104_corner");
        probe_a(10'd480, 10'd448, 12'h00F, "tick104_fill");
        probe_a(10'd511, 10'd479, 12'hFF0, "tick104_br");
        probe_a(10'd447, 10'd416, PAT, "tick104_left");
        probe_a(10'd451, 10'd420, 12'hFF0, "tick104_border");
        probe_a(10'd452, 10'd420, 12'h00F, "tick104_inner");
        tick_a(1);
        probe_a(10'd444, 10'd414, 12'hFF0, "tick105_corner");

        tick_b(143);
        probe_b(10'd574, 10'd574, 12'h000, 12'h0FF, "b143_corner");
        tick_b(1);
        probe_b(10'd576, 10'd576, 12'h000, 12'hF0F, "b_corner_outline");
        probe_b(10'd608, 10'd608, 12'h000, 12'h0F0, "b_corner_fill");
        probe_b(10'd575, 10'd600, 12'h000, PAT, "b_corner_left");

        tick_a(50);
        probe_a(10'd100, 10'd100, PAT, "pre_reset");
        #6;
        rst_n = 1'b0;
        #1;
        check("async_reset_a", {a_hs, a_vs, a_r, a_g, a_b}, 14'h3000);
        check("async_reset_b", {b_hs, b_vs, b_r, b_g, b_b}, 14'h3000);
        repeat (2) @(posedge iClk);
        #2;
        rst_n = 1'b1;
        #1;
        probe_a(10'd288, 10'd208, 12'h0FF, "rst_corner");
        probe_a(10'd320, 10'd240, 12'hF00, "rst_fill");
        probe_b(10'd288, 10'd288, PAT, 12'h0FF, "rst_b_corner");
        probe_b(10'd320, 10'd320, PAT, 12'hF00, "rst_b_fill");
        tick_a(1);
        probe_a(10'd292, 10'd210, 12'h0FF, "rst_tick_corner");
        probe_a(10'd320, 10'd240, 12'hF00, "rst_tick_fill");

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge iClk);
        if (sb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
